// File: rtl/enc8b10b_pkg.sv
// Shared 8b/10b code tables (RD- forms) and control-character legality.
package enc8b10b_pkg;

  typedef logic [9:0] code10_t;

  // 5b/6b code as seen from RD-, bits abcdei with 'a' in the MSB
  function automatic logic [5:0] enc6_rdm(input logic [4:0] x);
    logic [5:0] c;
    case (x)
      5'd0:  c = 6'b100111;  5'd1:  c = 6'b011101;  5'd2:  c = 6'b101101;
      5'd3:  c = 6'b110001;  5'd4:  c = 6'b110101;  5'd5:  c = 6'b101001;
      5'd6:  c = 6'b011001;  5'd7:  c = 6'b111000;  5'd8:  c = 6'b111001;
      5'd9:  c = 6'b100101;  5'd10: c = 6'b010101;  5'd11: c = 6'b110100;
      5'd12: c = 6'b001101;  5'd13: c = 6'b101100;  5'd14: c = 6'b011100;
      5'd15: c = 6'b010111;  5'd16: c = 6'b011011;  5'd17: c = 6'b100011;
      5'd18: c = 6'b010011;  5'd19: c = 6'b110010;  5'd20: c = 6'b001011;
      5'd21: c = 6'b101010;  5'd22: c = 6'b011010;  5'd23: c = 6'b111010;
      5'd24: c = 6'b110011;  5'd25: c = 6'b100110;  5'd26: c = 6'b010110;
      5'd27: c = 6'b110110;  5'd28: c = 6'b001110;  5'd29: c = 6'b101110;
      5'd30: c = 6'b011110;  default: c = 6'b101011;
    endcase
    return c;
  endfunction

  // 3b/4b data code entered at RD-, bits fghj ('f' in the MSB), primary D.x.7
  function automatic logic [3:0] enc4_rdm(input logic [2:0] y);
    logic [3:0] c;
    case (y)
      3'd0: c = 4'b1011;  3'd1: c = 4'b1001;  3'd2: c = 4'b0101;  3'd3: c = 4'b1100;
      3'd4: c = 4'b1101;  3'd5: c = 4'b1010;  3'd6: c = 4'b0110;  default: c = 4'b1110;
    endcase
    return c;
  endfunction

  // K28.y trailer when the 3b/4b block is entered at RD-; always inverted at RD+
  function automatic logic [3:0] k28_4b_rdm(input logic [2:0] y);
    logic [3:0] c;
    case (y)
      3'd0: c = 4'b1011;  3'd1: c = 4'b0110;  3'd2: c = 4'b1010;  3'd3: c = 4'b1100;
      3'd4: c = 4'b1101;  3'd5: c = 4'b0101;  3'd6: c = 4'b1001;  default: c = 4'b0111;
    endcase
    return c;
  endfunction

  function automatic logic k_legal(input logic [7:0] b);
    return (b[4:0] == 5'd28) || (b == 8'hF7) || (b == 8'hFB) ||
           (b == 8'hFD) || (b == 8'hFE);
  endfunction

endpackage

// File: rtl/enc_8b10b_lane.sv
// Combinational single-byte 8b/10b encoder with disparity in/out.
module enc_8b10b_lane
  import enc8b10b_pkg::*;
(
  input  logic [7:0] din_i,
  input  logic       k_i,
  input  logic       rd_i,
  output code10_t    code_o,
  output logic       rd_o,
  output logic       kerr_o
);

  logic [4:0] x;
  logic [2:0] y;
  logic       kv, bal6, bal4, rd_mid, alt7;
  logic [5:0] c6;
  logic [3:0] c4;

  always_comb begin
    x      = din_i[4:0];
    y      = din_i[7:5];
    kerr_o = k_i & ~k_legal(din_i);
    kv     = k_i & ~kerr_o;

    c6     = (kv && x == 5'd28) ? 6'b001111 : enc6_rdm(x);
    bal6   = ($countones(c6) == 3);
    rd_mid = rd_i ^ ~bal6;

    // D.x.7 switches to A7 where P7 would extend e,i into a run of five
    alt7 = (y == 3'd7) && (rd_mid ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                                  : (x == 5'd17 || x == 5'd18 || x == 5'd20));
    if (kv && x == 5'd28)  c4 = k28_4b_rdm(y);
    else if (kv || alt7)   c4 = 4'b0111;
    else                   c4 = enc4_rdm(y);
    bal4 = ($countones(c4) == 2);
    rd_o = rd_mid ^ ~bal4;

    // D.07 and D.x.3 are balanced but still have a distinct RD+ form
    code_o[9:4] = (rd_i && (!bal6 || x == 5'd7)) ? ~c6 : c6;
    code_o[3:0] = (rd_mid && (kv || !bal4 || y == 3'd3)) ? ~c4 : c4;
  end

endmodule

// File: rtl/encoder_8b10b_stream.sv
// Registered multi-lane 8b/10b encoder with valid/ready handshake and held running disparity.
module encoder_8b10b_stream
  import enc8b10b_pkg::*;
#(
  parameter int   LANES   = 2,
  parameter logic RD_INIT = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  S_VALID,
  output logic                  S_READY,
  input  logic [LANES-1:0]      K,
  input  logic [8*LANES-1:0]    D_IN,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic [10*LANES-1:0]   D_OUT,
  output logic [LANES-1:0]      KERR,
  output logic                  RD
);

  logic [LANES:0]          rd_c;
  logic [10*LANES-1:0]     code_w;
  logic [LANES-1:0]        kerr_w;
  logic                    m_valid_q, m_valid_d, rd_q, rd_d, accept;
  logic [10*LANES-1:0]     d_out_q, d_out_d;
  logic [LANES-1:0]        kerr_q, kerr_d;

  assign rd_c[0] = rd_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    enc_8b10b_lane u_lane (
      .din_i  (D_IN[8*i +: 8]),
      .k_i    (K[i]),
      .rd_i   (rd_c[i]),
      .code_o (code_w[10*i +: 10]),
      .rd_o   (rd_c[i+1]),
      .kerr_o (kerr_w[i])
    );
  end

  assign S_READY = !m_valid_q || M_READY;
  assign accept  = S_VALID && S_READY;

  always_comb begin
    m_valid_d = m_valid_q;
    d_out_d   = d_out_q;
    kerr_d    = kerr_q;
    rd_d      = rd_q;
    if (accept) begin
      m_valid_d = 1'b1;
      d_out_d   = code_w;
      kerr_d    = kerr_w;
      rd_d      = rd_c[LANES];
    end else if (M_READY) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      m_valid_q <= 1'b0;
      d_out_q   <= '0;
      kerr_q    <= '0;
      rd_q      <= RD_INIT;
    end else begin
      m_valid_q <= m_valid_d;
      d_out_q   <= d_out_d;
      kerr_q    <= kerr_d;
      rd_q      <= rd_d;
    end
  end

  assign M_VALID = m_valid_q;
  assign D_OUT   = d_out_q;
  assign KERR    = kerr_q;
  assign RD      = rd_q;

endmodule

// File: tb/tb_encoder_8b10b_stream.sv
// Scoreboard bench: driver pushes reference-model codes on accept, monitor checks outputs.
module tb_encoder_8b10b_stream;

  localparam logic RD_INIT = 1'b0;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        S_VALID = 1'b0;
  logic        S_READY;
  logic [1:0]  K = '0;
  logic [15:0] D_IN = '0;
  logic        M_VALID;
  logic        M_READY = 1'b0;
  logic [19:0] D_OUT;
  logic [1:0]  KERR;
  logic        RD;

  encoder_8b10b_stream #(.LANES(2), .RD_INIT(RD_INIT)) dut (
    .CLK(CLK), .RST(RST), .S_VALID(S_VALID), .S_READY(S_READY), .K(K), .D_IN(D_IN),
    .M_VALID(M_VALID), .M_READY(M_READY), .D_OUT(D_OUT), .KERR(KERR), .RD(RD)
  );

  always #5 CLK = ~CLK;

  // Reference tables straight from the code charts, RD- column
  localparam logic [5:0] T6 [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [3:0] P4M [8]  = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                                      4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [3:0] K28M [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                                      4'b0010, 4'b1010, 4'b0110, 4'b1000};
  localparam logic [7:0] KLEGAL [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                                         8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

  typedef struct {
    logic [19:0] code;
    logic [1:0]  kerr;
    logic        rd;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic mrd = RD_INIT;   // model RD including words not yet visible
  logic crd = RD_INIT;   // RD of the word most recently seen on the output

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", n, act, exp, $time);
    end
  endtask

  // One character: pick the form by running disparity, RD follows the ones count per sub-block
  task automatic ref_lane(input logic [7:0] b, input logic k, inout logic rd,
                          output logic [9:0] code, output logic kerr);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       rd0, kk;
    x    = b[4:0];
    y    = b[7:5];
    rd0  = rd;
    kerr = k && !(x == 28 || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30)));
    kk   = k && !kerr;
    c6   = (kk && x == 28) ? 6'b001111 : T6[x];
    if (rd && ($countones(c6) != 3 || c6 == 6'b111000)) c6 = ~c6;
    if ($countones(c6) > 3) rd = 1'b1;
    else if ($countones(c6) < 3) rd = 1'b0;
    if (kk) begin
      c4 = (x == 28) ? K28M[y] : 4'b1000;
      if (rd0) c4 = ~c4;
    end else begin
      c4 = P4M[y];
      if (rd && ($countones(c4) != 2 || c4 == 4'b1100)) c4 = ~c4;
      if (y == 7 && c6[1] == c6[0] && c6[0] == c4[3]) c4 = rd ? 4'b1000 : 4'b0111;
    end
    if ($countones(c4) > 2) rd = 1'b1;
    else if ($countones(c4) < 2) rd = 1'b0;
    code = {c6, c4};
  endtask

  task automatic drive(input bit rst, input bit v, input logic [1:0] k,
                       input logic [15:0] d, input bit mr);
    exp_t       e;
    logic       r, k0, k1;
    logic [9:0] c0, c1;
    @(negedge CLK);
    RST = rst; S_VALID = v; K = k; D_IN = d; M_READY = mr;
    #1;
    if (rst) begin
      q.delete();
      mrd = RD_INIT;
      crd = RD_INIT;
    end else if (v && S_READY) begin
      r = mrd;
      ref_lane(d[7:0], k[0], r, c0, k0);
      ref_lane(d[15:8], k[1], r, c1, k1);
      e.code = {c1, c0}; e.kerr = {k1, k0}; e.rd = r; e.cyc = cyc;
      q.push_back(e);
      mrd = r;
    end
  endtask

  // Monitor: front of queue must be on the output one cycle after its accept
  initial begin
    bit vis;
    forever begin
      @(negedge CLK);
      cyc++;
      #2;
      if (!RST) begin
        vis = (q.size() > 0) && (q[0].cyc < cyc);
        chk("m_valid", {31'b0, M_VALID}, {31'b0, vis});
        chk("s_ready", {31'b0, S_READY}, {31'b0, !vis || M_READY});
        if (vis) begin
          chk("d_out", {12'b0, D_OUT}, {12'b0, q[0].code});
          chk("kerr", {30'b0, KERR}, {30'b0, q[0].kerr});
          chk("rd", {31'b0, RD}, {31'b0, q[0].rd});
          crd = q[0].rd;
          if (M_READY) void'(q.pop_front());
        end else begin
          chk("rd_idle", {31'b0, RD}, {31'b0, crd});
        end
      end
    end
  end

  initial begin
    logic [19:0] held;
    logic        held_rd;
    logic [1:0]  kr;
    logic [15:0] dr;
    drive(1, 0, 2'b00, 16'h0000, 0);
    drive(1, 0, 2'b00, 16'h0000, 0);
    drive(0, 0, 2'b00, 16'h0000, 0);
    #2;
    chk("rst_m_valid", {31'b0, M_VALID}, 0);
    chk("rst_rd", {31'b0, RD}, {31'b0, RD_INIT});
    chk("rst_s_ready", {31'b0, S_READY}, 1);
    chk("rst_d_out", {12'b0, D_OUT}, 0);
    chk("rst_kerr", {30'b0, KERR}, 0);

    // K28.5 in both lanes from RD-: lane 0 RD- form, lane 1 RD+ form
    drive(0, 1, 2'b11, 16'hBCBC, 1);
    drive(0, 0, 2'b00, 16'h0000, 1);
    #2;
    chk("k285_pair", {12'b0, D_OUT}, {12'b0, 10'b1100000101, 10'b0011111010});
    chk("k285_rd", {31'b0, RD}, 0);

    // D21.5 is neutral, RD unchanged
    drive(0, 1, 2'b00, 16'hB5B5, 1);
    drive(0, 0, 2'b00, 16'h0000, 1);
    #2;
    chk("d215", {12'b0, D_OUT}, {12'b0, 10'b1010101010, 10'b1010101010});
    chk("d215_rd", {31'b0, RD}, 0);

    // Illegal K on 0x00 encodes as D0.0
    drive(0, 1, 2'b01, 16'hB500, 1);
    drive(0, 0, 2'b00, 16'h0000, 1);
    #2;
    chk("kerr_code", {22'b0, D_OUT[9:0]}, {22'b0, 10'b1001110100});
    chk("kerr_flag", {30'b0, KERR}, 2'b01);

    // Move to RD+, then D0.0 in both lanes uses the RD+ form
    drive(0, 1, 2'b01, 16'hB5BC, 1);
    drive(0, 1, 2'b00, 16'h0000, 1);
    drive(0, 0, 2'b00, 16'h0000, 1);
    #2;
    chk("d00_rdp", {12'b0, D_OUT}, {12'b0, 10'b0110001011, 10'b0110001011});
    chk("d00_rdp_rd", {31'b0, RD}, 1);

    // Backpressure: three stalled cycles, then release with no bubble
    drive(0, 1, 2'b00, 16'h1234, 1);
    drive(0, 1, 2'b00, 16'h5678, 0);
    #2; held = D_OUT; held_rd = RD;
    chk("bp_s_ready", {31'b0, S_READY}, 0);
    drive(0, 1, 2'b00, 16'h5678, 0);
    drive(0, 1, 2'b00, 16'h5678, 0);
    #2;
    chk("bp_hold", {12'b0, D_OUT}, {12'b0, held});
    chk("bp_rd", {31'b0, RD}, {31'b0, held_rd});
    drive(0, 1, 2'b00, 16'h5678, 1);
    drive(0, 0, 2'b00, 16'h0000, 1);
    #2;
    chk("bp_no_bubble", {31'b0, M_VALID}, 1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int l = 0; l < 2; l++) begin
        kr[l] = ($urandom_range(0, 5) == 0);
        dr[8*l +: 8] = (kr[l] && $urandom_range(0, 2) != 0) ? KLEGAL[$urandom_range(0, 11)]
                                                            : 8'($urandom);
      end
      drive(0, $urandom_range(0, 3) != 0, kr, dr, $urandom_range(0, 3) != 0);
    end

    // Reset mid-stream with a word pending and RD+
    drive(0, 1, mrd ? 2'b00 : 2'b01, mrd ? 16'hB5B5 : 16'hB5BC, 1);
    drive(0, 0, 2'b00, 16'h0000, 0);
    #2;
    chk("pre_rst_valid", {31'b0, M_VALID}, 1);
    chk("pre_rst_rd", {31'b0, RD}, 1);
    drive(1, 1, 2'b00, 16'h0000, 0);
    drive(0, 0, 2'b00, 16'h0000, 0);
    #2;
    chk("mid_rst_valid", {31'b0, M_VALID}, 0);
    chk("mid_rst_rd", {31'b0, RD}, {31'b0, RD_INIT});
    chk("mid_rst_ready", {31'b0, S_READY}, 1);

    for (int n = 0; n < 3; n++) drive(0, 0, 2'b00, 16'h0000, 1);
    chk("drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
